// File: rtl/align_pseudo_wrbuf.sv
// rtl/align_pseudo_wrbuf.sv - banked 1RW SRAM front-end with a FIFO write buffer and read forwarding
module align_pseudo_wrbuf #(
    parameter int NUMVBNK    = 8,
    parameter int BITVBNK    = 3,
    parameter int NUMSROW    = 256,
    parameter int BITSROW    = 8,
    parameter int BITDWSN    = 4,
    parameter int DWIDTH     = 128,
    parameter int SRAM_DELAY = 2,
    parameter int WBDEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_write,
    input  logic [BITVBNK-1:0]           mem_wr_bnk,
    input  logic [BITSROW-1:0]           mem_wr_adr,
    input  logic [BITDWSN-1:0]           mem_wr_dwsn,
    input  logic [DWIDTH-1:0]            mem_bw,
    input  logic [DWIDTH-1:0]            mem_din,
    input  logic                         mem_read,
    input  logic [BITVBNK-1:0]           mem_rd_bnk,
    input  logic [BITSROW-1:0]           mem_rd_adr,
    input  logic [BITDWSN-1:0]           mem_rd_dwsn,
    output logic                         mem_rd_vld,
    output logic [DWIDTH-1:0]            mem_rd_dout,
    output logic                         mem_rd_fwrd,
    output logic                         wr_rdy,
    output logic                         wb_ovf,
    output logic [NUMVBNK-1:0]           t_en,
    output logic [NUMVBNK-1:0]           t_wr,
    output logic [NUMVBNK*BITSROW-1:0]   t_adr,
    output logic [NUMVBNK*BITDWSN-1:0]   t_dwsn,
    output logic [NUMVBNK*DWIDTH-1:0]    t_bw,
    output logic [NUMVBNK*DWIDTH-1:0]    t_din,
    input  logic [NUMVBNK*DWIDTH-1:0]    t_dout
);

    localparam int PW   = $clog2(WBDEPTH);
    localparam int CW   = PW + 1;
    localparam int LAST = SRAM_DELAY - 1;

    logic [BITVBNK-1:0] wb_bnk  [WBDEPTH];
    logic [BITSROW-1:0] wb_adr  [WBDEPTH];
    logic [BITDWSN-1:0] wb_dwsn [WBDEPTH];
    logic [DWIDTH-1:0]  wb_bw   [WBDEPTH];
    logic [DWIDTH-1:0]  wb_din  [WBDEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic              wr_bnk_buffered;
    logic              direct_wr;
    logic              need_buf;
    logic              drain;
    logic              push;
    logic              drop;
    logic [BITVBNK-1:0] head_bnk;
    logic [DWIDTH-1:0] snap_mask;
    logic [DWIDTH-1:0] snap_data;

    logic [SRAM_DELAY-1:0] rp_vld;
    logic [BITVBNK-1:0]    rp_bnk  [SRAM_DELAY];
    logic [DWIDTH-1:0]     rp_mask [SRAM_DELAY];
    logic [DWIDTH-1:0]     rp_data [SRAM_DELAY];
    logic [DWIDTH-1:0]     sram_word;

    // Buffer lookups walk the live entries oldest to youngest so later writes override earlier bits.
    always_comb begin
        logic [PW-1:0] idx;
        wr_bnk_buffered = 1'b0;
        snap_mask       = '0;
        snap_data       = '0;
        idx             = '0;
        for (int i = 0; i < WBDEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if (wb_bnk[idx] == mem_wr_bnk)
                    wr_bnk_buffered = 1'b1;
                if (wb_bnk[idx] == mem_rd_bnk && wb_adr[idx] == mem_rd_adr &&
                    wb_dwsn[idx] == mem_rd_dwsn) begin
                    snap_mask = snap_mask | wb_bw[idx];
                    snap_data = (snap_data & ~wb_bw[idx]) | (wb_din[idx] & wb_bw[idx]);
                end
            end
        end
    end

    always_comb begin
        head_bnk   = wb_bnk[head];
        direct_wr  = mem_write && !(mem_read && mem_rd_bnk == mem_wr_bnk) && !wr_bnk_buffered;
        need_buf   = mem_write && !direct_wr;
        drain      = (count != '0) && !(mem_read && mem_rd_bnk == head_bnk) &&
                     !(direct_wr && mem_wr_bnk == head_bnk);
        push       = need_buf && ((count != CW'(WBDEPTH)) || drain);
        drop       = need_buf && !push;
        count_next = count + CW'(push) - CW'(drain);
    end

    // Per-bank port mux: read beats direct write beats buffer drain.
    always_comb begin
        t_en   = '0;
        t_wr   = '0;
        t_adr  = '0;
        t_dwsn = '0;
        t_bw   = '0;
        t_din  = '0;
        for (int b = 0; b < NUMVBNK; b++) begin
            if (mem_read && mem_rd_bnk == BITVBNK'(b)) begin
                t_en[b]                        = 1'b1;
                t_adr[b*BITSROW +: BITSROW]    = mem_rd_adr;
                t_dwsn[b*BITDWSN +: BITDWSN]   = mem_rd_dwsn;
            end else if (direct_wr && mem_wr_bnk == BITVBNK'(b)) begin
                t_en[b]                        = 1'b1;
                t_wr[b]                        = 1'b1;
                t_adr[b*BITSROW +: BITSROW]    = mem_wr_adr;
                t_dwsn[b*BITDWSN +: BITDWSN]   = mem_wr_dwsn;
                t_bw[b*DWIDTH +: DWIDTH]       = mem_bw;
                t_din[b*DWIDTH +: DWIDTH]      = mem_din;
            end else if (drain && head_bnk == BITVBNK'(b)) begin
                t_en[b]                        = 1'b1;
                t_wr[b]                        = 1'b1;
                t_adr[b*BITSROW +: BITSROW]    = wb_adr[head];
                t_dwsn[b*BITDWSN +: BITDWSN]   = wb_dwsn[head];
                t_bw[b*DWIDTH +: DWIDTH]       = wb_bw[head];
                t_din[b*DWIDTH +: DWIDTH]      = wb_din[head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wr_rdy <= 1'b1;
            wb_ovf <= 1'b0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (drain)
                head <= head + 1'b1;
            count  <= count_next;
            wr_rdy <= (count_next < CW'(WBDEPTH));
            if (drop)
                wb_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_bnk[tail]  <= mem_wr_bnk;
            wb_adr[tail]  <= mem_wr_adr;
            wb_dwsn[tail] <= mem_wr_dwsn;
            wb_bw[tail]   <= mem_bw;
            wb_din[tail]  <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_vld <= '0;
        end else begin
            rp_vld[0] <= mem_read;
            for (int s = 1; s < SRAM_DELAY; s++)
                rp_vld[s] <= rp_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        rp_bnk[0]  <= mem_rd_bnk;
        rp_mask[0] <= snap_mask;
        rp_data[0] <= snap_data;
        for (int s = 1; s < SRAM_DELAY; s++) begin
            rp_bnk[s]  <= rp_bnk[s-1];
            rp_mask[s] <= rp_mask[s-1];
            rp_data[s] <= rp_data[s-1];
        end
    end

    always_comb begin
        sram_word   = t_dout[rp_bnk[LAST]*DWIDTH +: DWIDTH];
        mem_rd_vld  = rp_vld[LAST];
        mem_rd_fwrd = rp_vld[LAST] && (rp_mask[LAST] != '0);
        mem_rd_dout = '0;
        if (rp_vld[LAST])
            mem_rd_dout = (sram_word & ~rp_mask[LAST]) | (rp_data[LAST] & rp_mask[LAST]);
    end

endmodule

// File: tb/tb_align_pseudo_wrbuf.sv
// tb/tb_align_pseudo_wrbuf.sv - directed scoreboard bench for align_pseudo_wrbuf
module tb_align_pseudo_wrbuf;

    localparam int NB = 8, BB = 3, BR = 8, BD = 4, DW = 128, SD = 2, WD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_write;
    logic [BB-1:0]     mem_wr_bnk;
    logic [BR-1:0]     mem_wr_adr;
    logic [BD-1:0]     mem_wr_dwsn;
    logic [DW-1:0]     mem_bw;
    logic [DW-1:0]     mem_din;
    logic              mem_read;
    logic [BB-1:0]     mem_rd_bnk;
    logic [BR-1:0]     mem_rd_adr;
    logic [BD-1:0]     mem_rd_dwsn;
    logic              mem_rd_vld;
    logic [DW-1:0]     mem_rd_dout;
    logic              mem_rd_fwrd;
    logic              wr_rdy;
    logic              wb_ovf;
    logic [NB-1:0]     t_en;
    logic [NB-1:0]     t_wr;
    logic [NB*BR-1:0]  t_adr;
    logic [NB*BD-1:0]  t_dwsn;
    logic [NB*DW-1:0]  t_bw;
    logic [NB*DW-1:0]  t_din;
    logic [NB*DW-1:0]  t_dout;

    align_pseudo_wrbuf #(
        .NUMVBNK(NB), .BITVBNK(BB), .NUMSROW(256), .BITSROW(BR), .BITDWSN(BD),
        .DWIDTH(DW), .SRAM_DELAY(SD), .WBDEPTH(WD)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_write(mem_write), .mem_wr_bnk(mem_wr_bnk), .mem_wr_adr(mem_wr_adr),
        .mem_wr_dwsn(mem_wr_dwsn), .mem_bw(mem_bw), .mem_din(mem_din),
        .mem_read(mem_read), .mem_rd_bnk(mem_rd_bnk), .mem_rd_adr(mem_rd_adr),
        .mem_rd_dwsn(mem_rd_dwsn), .mem_rd_vld(mem_rd_vld), .mem_rd_dout(mem_rd_dout),
        .mem_rd_fwrd(mem_rd_fwrd), .wr_rdy(wr_rdy), .wb_ovf(wb_ovf),
        .t_en(t_en), .t_wr(t_wr), .t_adr(t_adr), .t_dwsn(t_dwsn),
        .t_bw(t_bw), .t_din(t_din), .t_dout(t_dout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural banked SRAM with a two-cycle read latency.
    logic [DW-1:0] sram [0:32767];
    logic [DW-1:0] rd1  [NB];
    logic [DW-1:0] rd2  [NB];

    function automatic logic [14:0] key(input int b, input int r, input int d);
        return {3'(b), 8'(r), 4'(d)};
    endfunction

    function automatic logic [DW-1:0] init_val(input logic [14:0] k);
        return {8{1'b0, k}};
    endfunction

    initial begin
        for (int k = 0; k < 32768; k++) sram[k] = init_val(15'(k));
        for (int b = 0; b < NB; b++) begin
            rd1[b] = '0;
            rd2[b] = '0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (t_en[b]) begin
                if (t_wr[b])
                    sram[key(b, int'(t_adr[b*BR +: BR]), int'(t_dwsn[b*BD +: BD]))] <=
                        (sram[key(b, int'(t_adr[b*BR +: BR]), int'(t_dwsn[b*BD +: BD]))] & ~t_bw[b*DW +: DW]) |
                        (t_din[b*DW +: DW] & t_bw[b*DW +: DW]);
                else
                    rd1[b] <= sram[key(b, int'(t_adr[b*BR +: BR]), int'(t_dwsn[b*BD +: BD]))];
            end
            rd2[b] <= rd1[b];
        end
    end

    always_comb begin
        t_dout = '0;
        for (int b = 0; b < NB; b++) t_dout[b*DW +: DW] = rd2[b];
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fwrd;
        logic [31:0]   cyc;
    } exp_t;

    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        if (mem_rd_vld) begin
            if (sbq.size() == 0) begin
                chk("rd_unexpected_vld", 128'(mem_rd_vld), 128'(0));
            end else begin
                e = sbq.pop_front();
                chk("rd_dout", mem_rd_dout, e.data);
                chk("rd_fwrd", 128'(mem_rd_fwrd), 128'(e.fwrd));
                chk("rd_latency", 128'(cyc - int'(e.cyc)), 128'(SD));
            end
        end
    end

    task automatic idle();
        mem_write   = 1'b0;
        mem_wr_bnk  = '0;
        mem_wr_adr  = '0;
        mem_wr_dwsn = '0;
        mem_bw      = '0;
        mem_din     = '0;
        mem_read    = 1'b0;
        mem_rd_bnk  = '0;
        mem_rd_adr  = '0;
        mem_rd_dwsn = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int b, input int r, input int d, input logic [DW-1:0] bw,
                      input logic [DW-1:0] din);
        mem_write   = 1'b1;
        mem_wr_bnk  = BB'(b);
        mem_wr_adr  = BR'(r);
        mem_wr_dwsn = BD'(d);
        mem_bw      = bw;
        mem_din     = din;
    endtask

    task automatic rd(input int b, input int r, input int d, input logic [DW-1:0] exp,
                      input logic fw);
        exp_t e;
        mem_read    = 1'b1;
        mem_rd_bnk  = BB'(b);
        mem_rd_adr  = BR'(r);
        mem_rd_dwsn = BD'(d);
        e.data = exp;
        e.fwrd = fw;
        e.cyc  = 32'(cyc);
        sbq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] ones, lo, hi, xa, aa, d1, d2, merged, w;

    initial begin
        ones = '1;
        lo   = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        hi   = ~lo;
        xa   = {8{16'h1111}};
        aa   = {16{8'hAA}};
        d1   = {8{16'h0D01}};
        d2   = {8{16'h0D02}};
        merged = (d1 & lo) | (d2 & hi);

        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_rdy", 128'(wr_rdy), 128'(1));
        chk("rst_wb_ovf", 128'(wb_ovf), 128'(0));
        chk("rst_rd_vld", 128'(mem_rd_vld), 128'(0));
        chk("rst_rd_dout", mem_rd_dout, 128'(0));
        chk("rst_t_en", 128'(t_en), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // read bank 2 alongside a direct write to bank 5
        rd(2, 3, 1, init_val(key(2, 3, 1)), 1'b0);
        wr(5, 4, 0, ones, xa);
        @(negedge clk);
        chk("rw_t_en", 128'(t_en), 128'(8'b0010_0100));
        chk("rw_t_wr", 128'(t_wr), 128'(8'b0010_0000));
        chk("rw_t_adr5", 128'(t_adr[5*BR +: BR]), 128'(4));
        chk("rw_t_adr2", 128'(t_adr[2*BR +: BR]), 128'(3));
        tick();
        @(negedge clk);
        chk("rw_no_drain", 128'(t_en), 128'(0));
        rd(5, 4, 0, xa, 1'b0);
        tick();

        // same-bank write/read: read-before-write, then forwarding, then drain
        wr(3, 7, 2, ones, aa);
        rd(3, 7, 2, init_val(key(3, 7, 2)), 1'b0);
        @(negedge clk);
        chk("rbw_t_wr", 128'(t_wr), 128'(0));
        tick();
        rd(3, 7, 2, aa, 1'b1);
        tick();
        @(negedge clk);
        chk("drain_t_en", 128'(t_en), 128'(8'b0000_1000));
        chk("drain_t_wr", 128'(t_wr), 128'(8'b0000_1000));
        chk("drain_t_din", t_din[3*DW +: DW], aa);
        tick();
        rd(3, 7, 2, aa, 1'b0);
        tick();

        // two partial buffered writes merged on a forwarded read
        wr(4, 9, 3, lo, d1);
        rd(4, 1, 0, init_val(key(4, 1, 0)), 1'b0);
        tick();
        wr(4, 9, 3, hi, d2);
        rd(4, 1, 0, init_val(key(4, 1, 0)), 1'b0);
        tick();
        rd(4, 9, 3, merged, 1'b1);
        tick();
        tick();
        tick();
        rd(4, 9, 3, merged, 1'b0);
        tick();

        // overflow: five buffered writes against a four-entry buffer
        for (int i = 0; i < 5; i++) begin
            w = {16{8'(8'hC0 + i)}};
            wr(1, 10 + i, 0, ones, w);
            rd(1, 0, 0, init_val(key(1, 0, 0)), 1'b0);
            @(negedge clk);
            chk($sformatf("ovf_wr_rdy_%0d", i), 128'(wr_rdy), 128'(i < 4 ? 1 : 0));
            chk($sformatf("ovf_flag_pre_%0d", i), 128'(wb_ovf), 128'(0));
            tick();
        end
        @(negedge clk);
        chk("ovf_flag_set", 128'(wb_ovf), 128'(1));
        chk("ovf_full_rdy", 128'(wr_rdy), 128'(0));
        repeat (4) tick();
        @(negedge clk);
        chk("ovf_rdy_back", 128'(wr_rdy), 128'(1));
        for (int i = 0; i < 5; i++) begin
            w = {16{8'(8'hC0 + i)}};
            rd(1, 10 + i, 0, (i < 4) ? w : init_val(key(1, 14, 0)), 1'b0);
            tick();
        end
        repeat (4) tick();
        @(negedge clk);
        chk("ovf_sticky", 128'(wb_ovf), 128'(1));
        chk("sb_empty_mid", 128'(sbq.size()), 128'(0));
        tick();

        // reset one cycle after a read discards it
        mem_read   = 1'b1;
        mem_rd_bnk = 3'd0;
        mem_rd_adr = 8'd5;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("post_rst_wr_rdy", 128'(wr_rdy), 128'(1));
        chk("post_rst_wb_ovf", 128'(wb_ovf), 128'(0));
        chk("post_rst_dout", mem_rd_dout, 128'(0));
        chk("post_rst_t_en", 128'(t_en), 128'(0));
        chk("sb_empty_end", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/align_pseudo_wrbuf.md
ALIGN_PSEUDO_WRBUF -- requirements
Module: align_pseudo_wrbuf

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- NUMVBNK, 8, banks
- BITVBNK, 3, bank index width
- NUMSROW, 256, rows per bank
- BITSROW, 8, row address width
- BITDWSN, 4, dwsn select width
- DWIDTH, 128, SRAM word width (NUMWRDS*MEMWDTH)
- SRAM_DELAY, 2, SRAM read latency in cycles, >=1
- WBDEPTH, 4, write-buffer entries, power of 2, >=2

REQ-002 SHALL have these ports (name, direction, width, meaning); one clock, reset synchronous active-high:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- mem_write, in, 1, write request
- mem_wr_bnk, in, BITVBNK, write bank
- mem_wr_adr, in, BITSROW, write row
- mem_wr_dwsn, in, BITDWSN, write dwsn
- mem_bw, in, DWIDTH, bit-write mask
- mem_din, in, DWIDTH, write data
- mem_read, in, 1, read request
- mem_rd_bnk, in, BITVBNK, read bank
- mem_rd_adr, in, BITSROW, read row
- mem_rd_dwsn, in, BITDWSN, read dwsn
- mem_rd_vld, out, 1, read data valid
- mem_rd_dout, out, DWIDTH, read data
- mem_rd_fwrd, out, 1, buffer contributed to data
- wr_rdy, out, 1, buffer can accept a write
- wb_ovf, out, 1, sticky overflow error
- t_en, out, NUMVBNK, per-bank SRAM enable
- t_wr, out, NUMVBNK, per-bank write (1) / read (0)
- t_adr, out, NUMVBNK*BITSROW, per-bank row
- t_dwsn, out, NUMVBNK*BITDWSN, per-bank dwsn
- t_bw, out, NUMVBNK*DWIDTH, per-bank mask
- t_din, out, NUMVBNK*DWIDTH, per-bank data
- t_dout, in, NUMVBNK*DWIDTH, per-bank read data

Function
REQ-003 SHALL drive each bank as a single-port (1RW) SRAM: at most one of read/write per bank per cycle.
REQ-004 SHALL issue mem_read to bank mem_rd_bnk in the same cycle, combinationally (t_en=1, t_wr=0); reads always have priority.
REQ-005 SHALL write mem_write directly to the SRAM in the same cycle when both hold: mem_rd_bnk differs from mem_wr_bnk (or mem_read=0), and the buffer has no entry for mem_wr_bnk.
REQ-006 SHALL otherwise push the write {bnk, adr, dwsn, bw, din} into a FIFO write buffer of WBDEPTH entries, preserving per-bank order.
REQ-007 SHALL drain the buffer head to its bank each cycle that bank has no read and no direct write; drain is at most one entry per cycle and only the head.
REQ-008 SHALL allow a push and a drain in the same cycle; count is unchanged in that case.
REQ-009 SHALL drive wr_rdy = (count < WBDEPTH); the value is registered, from count after the previous cycle's update.
REQ-010 SHALL drop a write that needs buffering while count==WBDEPTH with no drain this cycle, and SHALL set wb_ovf=1 until reset.
REQ-011 SHALL assert mem_rd_vld exactly SRAM_DELAY cycles after mem_read, with mem_rd_dout taken from t_dout of the issued bank.
REQ-012 SHALL forward buffered data on a read: at issue, every buffered entry matching {bnk, adr, dwsn} is merged oldest-to-youngest into a mask/data snapshot (youngest wins per bit). The snapshot is pipelined SRAM_DELAY cycles. The output is mem_rd_dout = (t_dout & ~mask) | (data & mask).
REQ-013 SHALL set mem_rd_fwrd=1 with mem_rd_vld when the snapshot mask is nonzero, else 0.
REQ-014 SHALL give read-before-write semantics: a write pushed or directly written in the same cycle as a read is excluded from that read's snapshot. An entry draining in the read's cycle is still included.
REQ-015 SHALL drive t_* for idle banks as t_en=0 and all other t_* fields 0.
REQ-016 SHALL wrap FIFO head/tail pointers modulo WBDEPTH; count width is clog2(WBDEPTH)+1.

Reset
REQ-017 SHALL, while rst=1: empty the buffer (count=0), clear the read pipeline, set mem_rd_vld=0, mem_rd_fwrd=0, mem_rd_dout=0, wb_ovf=0, wr_rdy=1, t_en=0.
REQ-018 SHALL discard reads in flight when rst asserts mid-operation; no mem_rd_vld occurs for them after rst.

Verification
REQ-019 Read bank 2 and write bank 5 in the same cycle -> t_en[2]=1 with t_wr[2]=0, t_en[5]=1 with t_wr[5]=1; count stays 0.
REQ-020 Write bank 3 row 7 din=0xAA..AA with full bw, together with a read of bank 3 row 7 -> read returns the old SRAM value with fwrd=0; entry drains next idle cycle; a read 1 cycle later returns 0xAA..AA with fwrd=1 (if still buffered) or 0 (if drained).
REQ-021 5 writes to bank 1 while reading bank 1 every cycle (WBDEPTH=4) -> wr_rdy=0 after 4; 5th write dropped; wb_ovf=1.
REQ-022 Two buffered writes to the same address, bw low-half then high-half, followed by a read -> merged data from both; fwrd=1 at exactly SRAM_DELAY.
REQ-023 rst asserted the cycle after a read with SRAM_DELAY=2 -> mem_rd_vld stays 0; count=0; wr_rdy=1.
